// File: rtl/frame_ctrl_pkg.sv
// Shared definitions for the frame analysis controller.
//   state_t     : controller FSM states
//   ADDR_W_DEF  : default frame-buffer address width
//   RES_*       : analyzer colour codes as latched on res
package frame_ctrl_pkg;

  localparam int ADDR_W_DEF = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [2:0] RES_R    = 3'b100;
  localparam logic [2:0] RES_G    = 3'b010;
  localparam logic [2:0] RES_B    = 3'b001;
  localparam logic [2:0] RES_TIE  = 3'b111;
  localparam logic [2:0] RES_NONE = 3'b000;

endpackage

// File: rtl/cycle_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear.
//   clk, rst : clock, async active-high reset
//   clear    : zero the count (wins over enable)
//   en       : count this cycle
//   limit    : number of enabled cycles allowed
//   expired  : high during the enabled cycle that reaches limit
module cycle_watchdog #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;
  logic [W:0]   cnt_nxt;

  // cnt holds the number of enabled cycles already completed, so this
  // cycle is number cnt+1; expiry flags the cycle that equals limit.
  assign cnt_nxt = {1'b0, cnt} + {{W{1'b0}}, 1'b1};
  assign expired = en && (cnt_nxt >= {1'b0, limit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clear)         cnt <= '0;
    else if (en && !expired) cnt <= cnt_nxt[W-1:0];
  end

endmodule

// File: rtl/frame_analysis_ctrl.sv
// Frame analysis controller: freezes the camera buffer after a frame,
// runs the colour analyzer on the shared read port (display has priority),
// and hands the result to a consumer with a watchdog abort.
//   req_analyze    : request level, rising edge starts a cycle from IDLE
//   cam_frame_done : end-of-frame pulse from capture
//   vga_active/vga_addr : display read request/address
//   an_addr/an_done/an_res : analyzer read address, completion, colour code
//   res_ack        : consumer accepts result
//   mem_addr       : muxed frame-buffer read address
//   an_init/an_proc: analyzer start pulse / step enable (port grant)
//   cap_en         : camera write enable (0 freezes buffer)
//   busy/res_valid/err/res : status and latched result
module frame_analysis_ctrl
  import frame_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 65535,
  parameter bit AUTO    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_analyze,
  input  logic              cam_frame_done,
  input  logic              vga_active,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic [ADDR_W-1:0] an_addr,
  input  logic              an_done,
  input  logic [2:0]        an_res,
  input  logic              res_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              an_init,
  output logic              an_proc,
  output logic              cap_en,
  output logic              busy,
  output logic              res_valid,
  output logic              err,
  output logic [2:0]        res
);

  localparam logic [16:0] LIMIT = 17'(TIMEOUT);

  state_t state;
  logic   req_q;
  logic   wd_expired;

  cycle_watchdog #(.W(17)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == S_ARM),
    .en      (state == S_RUN),
    .limit   (LIMIT),
    .expired (wd_expired)
  );

  // Display owns the read port whenever it is active; analyzer only steps
  // on cycles the display leaves free.
  assign an_proc  = (state == S_RUN) && !vga_active;
  assign mem_addr = an_proc ? an_addr : vga_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      req_q     <= 1'b0;
      cap_en    <= 1'b1;
      an_init   <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      res       <= RES_NONE;
    end else begin
      req_q   <= req_analyze;
      an_init <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_analyze && !req_q) begin
            state <= S_WAIT_FRAME;
            busy  <= 1'b1;
          end
        end
        S_WAIT_FRAME: begin
          if (cam_frame_done) begin
            state   <= S_ARM;
            cap_en  <= 1'b0;
            an_init <= 1'b1;
          end
        end
        S_ARM: state <= S_RUN;
        S_RUN: begin
          // Completion takes precedence over a simultaneous expiry.
          if (an_done) begin
            res       <= an_res;
            err       <= 1'b0;
            res_valid <= 1'b1;
            cap_en    <= 1'b1;
            state     <= S_DONE;
          end else if (wd_expired) begin
            res       <= RES_NONE;
            err       <= 1'b1;
            res_valid <= 1'b1;
            cap_en    <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            if (AUTO) begin
              state <= S_WAIT_FRAME;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          cap_en <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_analysis_ctrl.sv
// Bench for frame_analysis_ctrl: two instances share one stimulus stream,
// A (AUTO=0, TIMEOUT=65535) and B (AUTO=1, TIMEOUT=100), each compared
// every cycle against a phase/counter reference model.
module tb_frame_analysis_ctrl;
  import frame_ctrl_pkg::*;

  localparam int AW = 15;
  localparam int P_IDLE = 0, P_WAIT = 1, P_ARM = 2, P_RUN = 3, P_DONE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_analyze = 0, cam_frame_done = 0, vga_active = 0, an_done = 0, res_ack = 0;
  logic [AW-1:0] vga_addr = '0, an_addr = '0;
  logic [2:0] an_res = '0;

  logic [AW-1:0] mem_addr_o [2];
  logic an_init_o [2], an_proc_o [2], cap_en_o [2], busy_o [2], rv_o [2], err_o [2];
  logic [2:0] res_o [2];

  always #5 clk = ~clk;

  frame_analysis_ctrl #(.ADDR_W(AW), .TIMEOUT(65535), .AUTO(1'b0)) dut_a (
    .clk(clk), .rst(rst), .req_analyze(req_analyze), .cam_frame_done(cam_frame_done),
    .vga_active(vga_active), .vga_addr(vga_addr), .an_addr(an_addr), .an_done(an_done),
    .an_res(an_res), .res_ack(res_ack), .mem_addr(mem_addr_o[0]), .an_init(an_init_o[0]),
    .an_proc(an_proc_o[0]), .cap_en(cap_en_o[0]), .busy(busy_o[0]), .res_valid(rv_o[0]),
    .err(err_o[0]), .res(res_o[0]));

  frame_analysis_ctrl #(.ADDR_W(AW), .TIMEOUT(100), .AUTO(1'b1)) dut_b (
    .clk(clk), .rst(rst), .req_analyze(req_analyze), .cam_frame_done(cam_frame_done),
    .vga_active(vga_active), .vga_addr(vga_addr), .an_addr(an_addr), .an_done(an_done),
    .an_res(an_res), .res_ack(res_ack), .mem_addr(mem_addr_o[1]), .an_init(an_init_o[1]),
    .an_proc(an_proc_o[1]), .cap_en(cap_en_o[1]), .busy(busy_o[1]), .res_valid(rv_o[1]),
    .err(err_o[1]), .res(res_o[1]));

  // reference model
  int   ph [2];
  int   run_cnt [2];
  logic [2:0] m_res [2];
  logic m_err [2], m_rv [2], m_req_prev [2];

  int n_cmp = 0, n_bad = 0;
  int vga_mode = 0, tog = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
    end
  endtask

  task automatic mreset(input int i);
    ph[i] = P_IDLE; run_cnt[i] = 0; m_res[i] = RES_NONE;
    m_err[i] = 0; m_rv[i] = 0; m_req_prev[i] = 0;
  endtask

  // One clock edge of controller behaviour, from the pre-edge inputs.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int tmo = (i == 0) ? 65535 : 100;
      bit au  = (i == 1);
      if (rst) begin
        mreset(i);
        continue;
      end
      case (ph[i])
        P_IDLE: if (req_analyze && !m_req_prev[i]) ph[i] = P_WAIT;
        P_WAIT: if (cam_frame_done) ph[i] = P_ARM;
        P_ARM:  begin run_cnt[i] = 0; ph[i] = P_RUN; end
        P_RUN: begin
          run_cnt[i]++;
          if (an_done) begin
            m_res[i] = an_res; m_err[i] = 0; m_rv[i] = 1; ph[i] = P_DONE;
          end else if (run_cnt[i] >= tmo) begin
            m_res[i] = RES_NONE; m_err[i] = 1; m_rv[i] = 1; ph[i] = P_DONE;
          end
        end
        default: if (res_ack) begin
          m_rv[i] = 0; ph[i] = au ? P_WAIT : P_IDLE;
        end
      endcase
      m_req_prev[i] = req_analyze;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic e_proc;
      if (rst) mreset(i);
      e_proc = (ph[i] == P_RUN) && !vga_active;
      chk($sformatf("busy%0d", i),    busy_o[i],    ph[i] != P_IDLE);
      chk($sformatf("cap_en%0d", i),  cap_en_o[i],  !(ph[i] == P_ARM || ph[i] == P_RUN));
      chk($sformatf("an_init%0d", i), an_init_o[i], ph[i] == P_ARM);
      chk($sformatf("an_proc%0d", i), an_proc_o[i], e_proc);
      chk($sformatf("mem_addr%0d", i), mem_addr_o[i], e_proc ? an_addr : vga_addr);
      chk($sformatf("res_valid%0d", i), rv_o[i],    m_rv[i]);
      chk($sformatf("err%0d", i),     err_o[i],     m_err[i]);
      chk($sformatf("res%0d", i),     res_o[i],     m_res[i]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
    vga_addr = AW'($urandom);
    an_addr  = AW'($urandom);
    if (vga_mode == 1) begin
      tog++;
      if (tog % 4 == 0) vga_active = !vga_active;
    end else if (vga_mode == 2) begin
      vga_active = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic request_and_frame(input int gap);
    req_analyze = 1; tick();
    req_analyze = 0; ticks(gap);
    cam_frame_done = 1; tick();
    cam_frame_done = 0;
  endtask

  task automatic ack();
    res_ack = 1; tick();
    res_ack = 0;
  endtask

  initial begin
    mreset(0); mreset(1);
    // reset state
    ticks(3);
    rst = 0;
    ticks(2);

    // long analysis, display idle, red result on A; B times out at 100
    vga_mode = 0; vga_active = 0;
    request_and_frame(5);
    chk("arm_an_init_a", an_init_o[0], 1'b1);
    chk("arm_cap_en_a", cap_en_o[0], 1'b0);
    ticks(19200);
    an_done = 1; an_res = RES_R; tick();
    an_done = 0;
    chk("long_res_a", res_o[0], RES_R);
    chk("long_valid_a", rv_o[0], 1'b1);
    chk("long_err_a", err_o[0], 1'b0);
    ticks(3);
    ack();
    ticks(2);

    // display toggling every 4 cycles during RUN
    request_and_frame(2);
    vga_mode = 1; tog = 0;
    ticks(40);
    an_done = 1; an_res = RES_G; tick();
    an_done = 0; vga_mode = 0; vga_active = 0;
    ack();
    ticks(2);

    // timeout on B while A keeps running; stray request edges in RUN
    request_and_frame(3);
    ticks(30);
    req_analyze = 1; ticks(3); req_analyze = 0;
    ticks(80);
    chk("tmo_err_b", err_o[1], 1'b1);
    chk("tmo_res_b", res_o[1], RES_NONE);
    chk("tmo_cap_b", cap_en_o[1], 1'b1);
    an_done = 1; an_res = RES_B; tick();
    an_done = 0;
    ack();
    ticks(2);

    // reset mid-RUN, then a normal run
    request_and_frame(1);
    vga_mode = 2;
    ticks(10);
    rst = 1; tick();
    rst = 0; ticks(2);
    request_and_frame(2);
    ticks(20);
    an_done = 1; an_res = RES_TIE; tick();
    an_done = 0;
    ack();
    vga_mode = 0; vga_active = 0;
    ticks(2);

    // completion on B's expiry cycle: result wins
    request_and_frame(2);
    tick();          // ARM
    ticks(99);       // RUN cycles 1..99
    an_done = 1; an_res = RES_G; tick();  // RUN cycle 100
    an_done = 0;
    chk("race_err_b", err_o[1], 1'b0);
    chk("race_res_b", res_o[1], RES_G);
    chk("race_valid_b", rv_o[1], 1'b1);
    ack();
    ticks(2);

    // randomized traffic
    vga_mode = 2;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) req_analyze = !req_analyze;
      cam_frame_done = ($urandom_range(0, 9) == 0);
      an_done = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: an_res = RES_R;
        1: an_res = RES_G;
        2: an_res = RES_B;
        default: an_res = RES_TIE;
      endcase
      res_ack = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0; ticks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
